// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: segment
// encoding, the load handshake state type and a width helper.
package ssd_pkg;

  // All segments dark (outputs are active-low)
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Load handshake: IDLE accepts a value, PENDING waits for a frame boundary
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } hs_state_e;

  // Counter width for a modulus n, never narrower than one bit
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_digit_timer.sv
// Scan timing for the seven-segment controller: cycle counter within a
// digit period, PWM slot, digit index, frame boundary and blink phase.
module ssd_digit_timer
  import ssd_pkg::*;
#(
  parameter int DIGIT_CYCLES = 1600,
  parameter int NUM_DIGITS   = 8,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [clog2w(DIGIT_CYCLES)-1:0]   cyc_cnt,
  output logic [BRIGHT_W-1:0]               slot,
  output logic [clog2w(NUM_DIGITS)-1:0]     digit_idx,
  output logic                              frame_tick,
  output logic                              frame_done,
  output logic                              blink_phase
);

  localparam int CYC_W    = clog2w(DIGIT_CYCLES);
  localparam int IDX_W    = clog2w(NUM_DIGITS);
  localparam int SLOT_LEN = DIGIT_CYCLES >> BRIGHT_W;
  localparam int SUB_W    = clog2w(SLOT_LEN);
  localparam int BF_W     = clog2w(BLINK_FRAMES);

  localparam logic [CYC_W-1:0]    CYC_LAST = CYC_W'(DIGIT_CYCLES - 1);
  localparam logic [CYC_W-1:0]    CYC_ONE  = CYC_W'(1);
  localparam logic [SUB_W-1:0]    SUB_LAST = SUB_W'(SLOT_LEN - 1);
  localparam logic [SUB_W-1:0]    SUB_ONE  = SUB_W'(1);
  localparam logic [BRIGHT_W-1:0] SLOT_ONE = BRIGHT_W'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
  localparam logic [BF_W-1:0]     BF_LAST  = BF_W'(BLINK_FRAMES - 1);
  localparam logic [BF_W-1:0]     BF_ONE   = BF_W'(1);

  logic [CYC_W-1:0]    cyc_cnt_r;
  logic [SUB_W-1:0]    sub_cnt_r;
  logic [BRIGHT_W-1:0] slot_r;
  logic [IDX_W-1:0]    digit_idx_r;
  logic                frame_done_r;
  logic [BF_W-1:0]     blink_cnt_r;
  logic                blink_phase_r;
  logic                digit_end_s;
  logic                frame_tick_s;

  // Detect the last cycle of a digit period and of a whole frame
  always_comb begin
    digit_end_s  = (cyc_cnt_r == CYC_LAST);
    frame_tick_s = digit_end_s && (digit_idx_r == IDX_LAST);
  end

  // Cycle counter and PWM slot; slot advances every SLOT_LEN cycles so it
  // always equals cyc_cnt / SLOT_LEN without a divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_r <= '0;
      sub_cnt_r <= '0;
      slot_r    <= '0;
    end else if (digit_end_s) begin
      cyc_cnt_r <= '0;
      sub_cnt_r <= '0;
      slot_r    <= '0;
    end else begin
      cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
      if (sub_cnt_r == SUB_LAST) begin
        sub_cnt_r <= '0;
        slot_r    <= slot_r + SLOT_ONE;
      end else begin
        sub_cnt_r <= sub_cnt_r + SUB_ONE;
      end
    end
  end

  // Digit index wraps at the end of the frame; frame_done follows the boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_idx_r  <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_tick_s;
      if (digit_end_s) begin
        digit_idx_r <= (digit_idx_r == IDX_LAST) ? '0 : digit_idx_r + IDX_ONE;
      end else begin
        digit_idx_r <= digit_idx_r;
      end
    end
  end

  // Blink phase toggles after every BLINK_FRAMES completed frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (frame_tick_s) begin
      if (blink_cnt_r == BF_LAST) begin
        blink_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BF_ONE;
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
    end
  end

  assign cyc_cnt     = cyc_cnt_r;
  assign slot        = slot_r;
  assign digit_idx   = digit_idx_r;
  assign frame_tick  = frame_tick_s;
  assign frame_done  = frame_done_r;
  assign blink_phase = blink_phase_r;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed N-digit seven-segment scan controller with PWM brightness,
// blink, leading-zero suppression and a frame-aligned load handshake.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int CLK_FREQUENCY          = 100_000_000,
  parameter int MIN_SEGMENT_DISPLAY_US = 16,
  parameter int NUM_DIGITS             = 8,
  parameter int BRIGHT_W               = 4,
  parameter int BLINK_FRAMES           = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [NUM_DIGITS*4-1:0] display_val,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    blank,
  output logic [6:0]              segments,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done,
  output logic                    update_done
);

  localparam int DIGIT_CYCLES = CLK_FREQUENCY / 1_000_000 * MIN_SEGMENT_DISPLAY_US;
  localparam int CYC_W        = clog2w(DIGIT_CYCLES);
  localparam int IDX_W        = clog2w(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] DIGIT0_SEL = NUM_DIGITS'(1);

  // Reject configurations where the slots do not tile the digit period
  generate
    if ((DIGIT_CYCLES < (2 ** BRIGHT_W)) || ((DIGIT_CYCLES % (2 ** BRIGHT_W)) != 0) ||
        (NUM_DIGITS < 1) || (NUM_DIGITS > 16)) begin : g_param_check
      $fatal(1, "ssd_scan_ctrl: DIGIT_CYCLES must be a multiple of 2**BRIGHT_W and NUM_DIGITS in 1..16");
    end
  endgenerate

  logic [CYC_W-1:0]            cyc_cnt_s;
  logic [BRIGHT_W-1:0]         slot_s;
  logic [IDX_W-1:0]            digit_idx_s;
  logic                        frame_tick_s;
  logic                        frame_done_s;
  logic                        blink_phase_s;

  hs_state_e                   state_r;
  logic                        load_ready_r;
  logic                        update_done_r;
  logic [NUM_DIGITS*4-1:0]     shadow_val_r;
  logic [NUM_DIGITS-1:0]       shadow_dp_r;
  logic [NUM_DIGITS*4-1:0]     active_val_r;
  logic [NUM_DIGITS-1:0]       active_dp_r;

  logic [3:0]                  nibbles_s [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]       lz_mask_s;
  logic [3:0]                  nib_s;
  logic                        dp_bit_s;
  logic                        suppress_s;
  logic                        blink_dark_s;
  logic                        in_window_s;
  logic [NUM_DIGITS-1:0]       digit_sel_s;
  logic [NUM_DIGITS-1:0]       an_nxt_s;
  logic [6:0]                  seg_nxt_s;
  logic                        dp_nxt_s;

  logic [NUM_DIGITS-1:0]       an_r;
  logic [6:0]                  seg_r;
  logic                        dp_out_r;

  ssd_digit_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .NUM_DIGITS   (NUM_DIGITS),
    .BRIGHT_W     (BRIGHT_W),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .cyc_cnt     (cyc_cnt_s),
    .slot        (slot_s),
    .digit_idx   (digit_idx_s),
    .frame_tick  (frame_tick_s),
    .frame_done  (frame_done_s),
    .blink_phase (blink_phase_s)
  );

  // Load handshake: capture into the shadow, commit to active only at a
  // frame boundary so a frame never shows a mix of old and new digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      load_ready_r  <= 1'b0;
      update_done_r <= 1'b0;
      shadow_val_r  <= '0;
      shadow_dp_r   <= '0;
      active_val_r  <= '0;
      active_dp_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          update_done_r <= 1'b0;
          if (load_valid && load_ready_r) begin
            shadow_val_r <= display_val;
            shadow_dp_r  <= dp;
            load_ready_r <= 1'b0;
            state_r      <= PENDING;
          end else begin
            load_ready_r <= 1'b1;
          end
        end
        PENDING: begin
          load_ready_r <= 1'b0;
          if (frame_tick_s) begin
            active_val_r  <= shadow_val_r;
            active_dp_r   <= shadow_dp_r;
            update_done_r <= 1'b1;
            state_r       <= IDLE;
          end else begin
            update_done_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          load_ready_r  <= 1'b0;
          update_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Split the active value into nibbles and mark the leading-zero run;
  // digit 0 is never part of the run
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lz_mask_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nibbles_s[i] = active_val_r[i*4 +: 4];
    end
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (nibbles_s[i] == 4'h0);
      lz_mask_s[i] = zero_run;
    end
  end

  // Decide what the current digit shows this cycle
  always_comb begin
    nib_s        = nibbles_s[digit_idx_s];
    dp_bit_s     = active_dp_r[digit_idx_s];
    suppress_s   = lz_en & lz_mask_s[digit_idx_s];
    blink_dark_s = blink_phase_s & blink_mask[digit_idx_s];
    in_window_s  = (cyc_cnt_s != '0) && (slot_s <= brightness);
    digit_sel_s  = DIGIT0_SEL << digit_idx_s;
    if (blank || !in_window_s || blink_dark_s) begin
      an_nxt_s  = '1;
      seg_nxt_s = SEG_OFF;
      dp_nxt_s  = 1'b1;
    end else if (suppress_s) begin
      if (dp_bit_s) begin
        an_nxt_s  = ~digit_sel_s;
        seg_nxt_s = SEG_OFF;
        dp_nxt_s  = 1'b0;
      end else begin
        an_nxt_s  = '1;
        seg_nxt_s = SEG_OFF;
        dp_nxt_s  = 1'b1;
      end
    end else begin
      an_nxt_s  = ~digit_sel_s;
      seg_nxt_s = hex_to_seg(nib_s);
      dp_nxt_s  = ~dp_bit_s;
    end
  end

  // Register the pin outputs so they only change on clock edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r     <= '1;
      seg_r    <= SEG_OFF;
      dp_out_r <= 1'b1;
    end else begin
      an_r     <= an_nxt_s;
      seg_r    <= seg_nxt_s;
      dp_out_r <= dp_nxt_s;
    end
  end

  assign load_ready  = load_ready_r;
  assign update_done = update_done_r;
  assign frame_done  = frame_done_s;
  assign an_out      = an_r;
  assign segments    = seg_r;
  assign dp_out      = dp_out_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl at a reduced clock: 2 MHz * 16 us gives
// 32 cycles per digit, 2-cycle PWM slots and 256-cycle frames.
module tb_ssd_scan_ctrl;

  localparam int NUM_DIGITS = 8;
  localparam int BRIGHT_W   = 4;
  localparam int DC         = 32;
  localparam int FRAME      = DC * NUM_DIGITS;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    load_valid;
  logic                    load_ready;
  logic [NUM_DIGITS*4-1:0] display_val;
  logic [NUM_DIGITS-1:0]   dp_v;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_en;
  logic [BRIGHT_W-1:0]     brightness;
  logic                    blank;
  logic [6:0]              segments;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_done;
  logic                    update_done;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cnt     [NUM_DIGITS];
  logic [6:0] seg_obs [NUM_DIGITS];
  logic       dp_obs  [NUM_DIGITS];

  ssd_scan_ctrl #(
    .CLK_FREQUENCY          (2_000_000),
    .MIN_SEGMENT_DISPLAY_US (16),
    .NUM_DIGITS             (NUM_DIGITS),
    .BRIGHT_W               (BRIGHT_W),
    .BLINK_FRAMES           (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .display_val (display_val),
    .dp          (dp_v),
    .blink_mask  (blink_mask),
    .lz_en       (lz_en),
    .brightness  (brightness),
    .blank       (blank),
    .segments    (segments),
    .dp_out      (dp_out),
    .an_out      (an_out),
    .frame_done  (frame_done),
    .update_done (update_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Align to a frame_done cycle, then record one full frame of outputs
  task automatic measure_frame();
    int guard;
    int multi;
    guard = 0;
    multi = 0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      cnt[d]     = 0;
      seg_obs[d] = 7'h7F;
      dp_obs[d]  = 1'b1;
    end
    while (frame_done !== 1'b1 && guard < FRAME + 8) begin
      @(negedge clk);
      guard++;
    end
    check("frame_sync", 32'(frame_done), 32'd1);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if ($countones(~an_out) > 1) multi++;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (an_out[d] == 1'b0) begin
          cnt[d]++;
          seg_obs[d] = segments;
          dp_obs[d]  = dp_out;
        end
      end
    end
    check("one_hot", 32'(multi), 32'd0);
  endtask

  task automatic load_value(input logic [31:0] val, input logic [7:0] dpv, input string tag);
    int guard;
    guard = 0;
    while (load_ready !== 1'b1 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, 32'(load_ready), 32'd1);
    display_val = val;
    dp_v        = dpv;
    load_valid  = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check({tag, "_busy"}, 32'(load_ready), 32'd0);
    guard = 0;
    while (update_done !== 1'b1 && guard < FRAME + 4) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_commit"}, 32'(update_done), 32'd1);
  endtask

  // Count digits that differ from a uniform expected value in the last frame
  function automatic int count_bad(input logic [6:0] exp_seg, input int exp_cnt);
    int bad;
    bad = 0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (seg_obs[d] !== exp_seg || cnt[d] != exp_cnt) bad++;
    end
    return bad;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int prev0;
    int found;
    rst         = 1'b1;
    load_valid  = 1'b0;
    display_val = '0;
    dp_v        = '0;
    blink_mask  = '0;
    lz_en       = 1'b0;
    brightness  = 4'hF;
    blank       = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an_out), 32'h0000_00FF);
    check("rst_seg", 32'(segments), 32'h0000_007F);
    check("rst_dp", 32'(dp_out), 32'd1);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_update_done", 32'(update_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(load_ready), 32'd1);

    // DEADBEEF, dp on digits 7..4, full brightness
    load_value(32'hDEAD_BEEF, 8'hF0, "ld1");
    measure_frame();
    for (int d = 0; d < NUM_DIGITS; d++) check($sformatf("full_on_%0d", d), 32'(cnt[d]), 32'd31);
    check("d0_seg", 32'(seg_obs[0]), 32'h0E);
    check("d0_dp", 32'(dp_obs[0]), 32'd1);
    check("d3_seg", 32'(seg_obs[3]), 32'h03);
    check("d3_dp", 32'(dp_obs[3]), 32'd1);
    check("d4_seg", 32'(seg_obs[4]), 32'h21);
    check("d4_dp", 32'(dp_obs[4]), 32'd0);
    check("d7_seg", 32'(seg_obs[7]), 32'h21);
    check("d7_dp", 32'(dp_obs[7]), 32'd0);

    // Brightness 3: slots 0..3 of 2 cycles, minus the anti-ghost cycle
    brightness = 4'h3;
    measure_frame();
    for (int d = 0; d < NUM_DIGITS; d++) check($sformatf("bright3_%0d", d), 32'(cnt[d]), 32'd7);
    brightness = 4'h0;
    measure_frame();
    check("bright0_d0", 32'(cnt[0]), 32'd1);
    check("bright0_d7", 32'(cnt[7]), 32'd1);
    brightness = 4'hF;

    // Leading-zero suppression on 00000A05
    lz_en = 1'b1;
    load_value(32'h0000_0A05, 8'h00, "ld2");
    measure_frame();
    for (int d = 3; d < NUM_DIGITS; d++) check($sformatf("lz_dark_%0d", d), 32'(cnt[d]), 32'd0);
    check("lz_d2_on", 32'(cnt[2]), 32'd31);
    check("lz_d2_seg", 32'(seg_obs[2]), 32'h08);
    check("lz_d1_seg", 32'(seg_obs[1]), 32'h40);
    check("lz_d0_seg", 32'(seg_obs[0]), 32'h12);
    lz_en = 1'b0;
    measure_frame();
    for (int d = 0; d < NUM_DIGITS; d++) check($sformatf("nolz_on_%0d", d), 32'(cnt[d]), 32'd31);
    check("nolz_d7_seg", 32'(seg_obs[7]), 32'h40);

    // Suppressed digit with dp shows only its dp
    lz_en = 1'b1;
    load_value(32'h0000_0A05, 8'h10, "ld3");
    measure_frame();
    check("lzdp_d4_on", 32'(cnt[4]), 32'd31);
    check("lzdp_d4_seg", 32'(seg_obs[4]), 32'h7F);
    check("lzdp_d4_dp", 32'(dp_obs[4]), 32'd0);
    check("lzdp_d5_dark", 32'(cnt[5]), 32'd0);
    check("lzdp_d3_dark", 32'(cnt[3]), 32'd0);
    lz_en = 1'b0;

    // Back-to-back loads with load_valid held high
    guard = 0;
    while (load_ready !== 1'b1 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    display_val = 32'h1111_1111;
    dp_v        = 8'h00;
    load_valid  = 1'b1;
    @(negedge clk);
    check("b2b_busy", 32'(load_ready), 32'd0);
    display_val = 32'h2222_2222;
    guard = 0;
    while (update_done !== 1'b1 && guard < FRAME + 4) begin
      check("b2b_ready_low", 32'(load_ready), 32'd0);
      @(negedge clk);
      guard++;
    end
    check("b2b_first_commit", 32'(update_done), 32'd1);
    check("b2b_ready_at_commit", 32'(load_ready), 32'd0);
    fork
      measure_frame();
      begin
        @(negedge clk);
        check("b2b_ready_back", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        check("b2b_second_taken", 32'(load_ready), 32'd0);
      end
    join
    check("b2b_frame1", 32'(count_bad(7'h79, 31)), 32'd0);
    check("b2b_second_commit", 32'(update_done), 32'd1);
    measure_frame();
    check("b2b_frame2", 32'(count_bad(7'h24, 31)), 32'd0);

    // Blink digit 0 with a 2-frame half-period
    blink_mask = 8'h01;
    measure_frame();
    prev0 = cnt[0];
    found = 0;
    for (int k = 0; k < 4; k++) begin
      if (found == 0) begin
        measure_frame();
        if (prev0 != 0 && cnt[0] == 0) found = 1;
        else prev0 = cnt[0];
      end
    end
    check("blink_edge", 32'(found), 32'd1);
    measure_frame();
    check("blink_dark2", 32'(cnt[0]), 32'd0);
    check("blink_other", 32'(cnt[1]), 32'd31);
    measure_frame();
    check("blink_lit1", 32'(cnt[0]), 32'd31);
    measure_frame();
    check("blink_lit2", 32'(cnt[0]), 32'd31);
    measure_frame();
    check("blink_dark_again", 32'(cnt[0]), 32'd0);
    blink_mask = 8'h00;

    // Blank forces every anode off
    blank = 1'b1;
    measure_frame();
    check("blank_all_off", 32'(count_bad(7'h7F, 0)), 32'd0);
    blank = 1'b0;

    // Reset while PENDING and mid-digit
    display_val = 32'h1234_5678;
    dp_v        = 8'hFF;
    load_valid  = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check("pend_busy", 32'(load_ready), 32'd0);
    repeat (40) @(negedge clk);
    check("pend_still", 32'(load_ready), 32'd0);
    check("pre_rst_an", 32'(an_out), 32'h0000_00FD);
    #2 rst = 1'b1;
    #1;
    check("async_an", 32'(an_out), 32'h0000_00FF);
    check("async_seg", 32'(segments), 32'h0000_007F);
    check("async_dp", 32'(dp_out), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(load_ready), 32'd1);
    measure_frame();
    check("post_rst_value", 32'(count_bad(7'h40, 31)), 32'd0);
    check("post_rst_dp", 32'(dp_obs[0]), 32'd1);
    check("post_rst_no_commit", 32'(update_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
